mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  RV32IM MEM stage plus MEM/WB pipeline register; directly feeds the write-back result mux.
//  Runs loads/stores on a req/ack data-memory bus, byte-lane aligns stores, sign/zero-extends loads.
//  Registers all write-back operands and controls; stalls upstream while a bus access is pending.
// PARAMETERS
//  TIMEOUT   16  max ACCESS cycles waiting for dmem_ack before abort (>=1)
//  CNT_W     5   timeout counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk              in   1   clock, rising edge
//  rst_n            in   1   asynchronous active-low reset
//  valid_M          in   1   M-stage instruction valid
//  ALU_out_M        in   32  ALU result / effective address
//  write_data_M     in   32  store data (rs2)
//  funct3_M         in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  ld_M, st_M       in   1   load / store
//  jal_M, jalr_M, lui_M, reg_write_M  in  1 each  passthrough controls
//  PCplus4_M, immediate_M  in  32 each  passthrough operands
//  rd_M             in   5   destination register
//  dmem_req         out  1   bus request, held until ack or timeout
//  dmem_we          out  1   1 = store
//  dmem_addr        out  32  {ALU_out_M[31:2],2'b00}
//  dmem_wdata       out  32  lane-replicated store data
//  dmem_be          out  4   byte enables
//  dmem_rdata       in   32  read data, valid with dmem_ack
//  dmem_ack         in   1   single-cycle completion strobe
//  stall_M          out  1   hold M-stage inputs stable
//  valid_W, ld_W, jal_W, jalr_W, lui_W, reg_write_W  out  1 each  registered controls to WB
//  ALU_out_W, mem_read_data_W, PCplus4_W, immediate_W  out  32 each  registered operands to WB
//  rd_W             out  5   registered destination
//  bus_err_W        out  1   access aborted by timeout
//  misalign_W       out  1   misaligned access trapped (only with MISALIGN_TRAP_EN)
// BEHAVIOUR
//  Reset: state IDLE, counter 0, dmem_req/dmem_we 0, all *_W outputs 0; async assert drops dmem_req at once.
//  FSM IDLE: valid_M & (ld_M|st_M) -> ACCESS, stall_M=1 combinationally, W regs load bubble (valid_W=0).
//   otherwise non-mem op: W regs load M inputs next edge (1-cycle latency), stall_M=0.
//  FSM ACCESS: dmem_req=1 (registered, first asserted 1 cycle after entry), dmem_we=st_M.
//   dmem_ack: stall_M=0, W regs load M inputs + extended load data, -> IDLE. Min load latency 2 cycles.
//   !dmem_ack: stall_M=1, counter++; counter==TIMEOUT-1 -> abort: dmem_req drops,
//   W regs load with bus_err_W=1, reg_write_W=0, -> IDLE. Late ack after abort ignored.
//  Both ld_M and st_M set: treated as load. valid_M=0 in IDLE: bubble, no bus activity.
//  Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{b}}; SH be=addr[1]?1100:0011, wdata={2{h}}; SW 1111.
//  Load: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
//  Stores: mem_read_data_W=0; reg_write_W passes reg_write_M unchanged.
//  bus_err_W/misalign_W clear on the next W-register load.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> no bus access,
//   stays IDLE, 1-cycle pass with misalign_W=1, reg_write_W=0, valid_W=1.
//  Not defined: misalign_W port absent; low address bits ignored
//   (H uses lane addr[1], W uses aligned word); access proceeds normally.
// TESTING
//  ALU op, ALU_out_M=0x1234 -> next cycle ALU_out_W=0x1234, valid_W=1, no dmem_req.
//  LB addr 0x103, ack after 3 cycles with rdata 0x80FF_FF_FF -> mem_read_data_W=0xFFFFFF80; stall_M high 3 cycles.
//  SH addr 0x102 data 0xABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
//  No ack for TIMEOUT=16 -> dmem_req drops after 16 cycles, bus_err_W=1, reg_write_W=0.
//  rst_n low mid-ACCESS -> dmem_req=0 immediately, valid_W=0, state IDLE after release.
//  MISALIGN_TRAP_EN: LW addr 0x101 -> misalign_W=1, no dmem_req; undefined: dmem_addr=0x100.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32IM MEM stage plus MEM/WB register: req/ack data bus, store lane alignment, load extension.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them on the bus.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_M,
    input  logic [31:0]               ALU_out_M,
    input  logic [31:0]               write_data_M,
    input  logic [2:0]                funct3_M,
    input  logic                      ld_M,
    input  logic                      st_M,
    input  logic                      jal_M,
    input  logic                      jalr_M,
    input  logic                      lui_M,
    input  logic                      reg_write_M,
    input  logic [31:0]               PCplus4_M,
    input  logic [31:0]               immediate_M,
    input  logic [4:0]                rd_M,
    mem_access_stage_if.master        dmem,
    output logic                      stall_M,
    output logic                      valid_W,
    output logic                      ld_W,
    output logic                      jal_W,
    output logic                      jalr_W,
    output logic                      lui_W,
    output logic                      reg_write_W,
    output logic [31:0]               ALU_out_W,
    output logic [31:0]               mem_read_data_W,
    output logic [31:0]               PCplus4_W,
    output logic [31:0]               immediate_W,
    output logic [4:0]                rd_W,
    output logic                      bus_err_W
`ifdef MISALIGN_TRAP_EN
   ,output logic                      misalign_W
`endif
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    typedef struct packed {
        logic        valid;
        logic        ld;
        logic        jal;
        logic        jalr;
        logic        lui;
        logic        reg_write;
        logic        bus_err;
`ifdef MISALIGN_TRAP_EN
        logic        misalign;
`endif
        logic [31:0] alu_out;
        logic [31:0] mem_rdata;
        logic [31:0] pc_plus4;
        logic [31:0] imm;
        logic [4:0]  rd;
    } wb_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    wb_t              wb_q, wb_d;

    logic             is_mem;
    logic             misalign;
    logic             pass;
    logic             abort;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_ext;

    assign is_mem = valid_M & (ld_M | st_M);

    // funct3[1:0]: 00 byte, 01 half, otherwise word.
`ifdef MISALIGN_TRAP_EN
    assign misalign = is_mem & (((funct3_M[1:0] == 2'b01) & ALU_out_M[0]) |
                                (funct3_M[1] & (ALU_out_M[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign dmem.dmem_req  = req_q;
    assign dmem.dmem_we   = we_q;
    assign dmem.dmem_addr = {ALU_out_M[31:2], 2'b00};

    always_comb begin
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = write_data_M;
        if (funct3_M[1:0] == 2'b00) begin
            dmem.dmem_be    = 4'b0001 << ALU_out_M[1:0];
            dmem.dmem_wdata = {4{write_data_M[7:0]}};
        end else if (funct3_M[1:0] == 2'b01) begin
            dmem.dmem_be    = ALU_out_M[1] ? 4'b1100 : 4'b0011;
            dmem.dmem_wdata = {2{write_data_M[15:0]}};
        end
    end

    always_comb begin
        unique case (ALU_out_M[1:0])
            2'b00: byte_sel = dmem.dmem_rdata[7:0];
            2'b01: byte_sel = dmem.dmem_rdata[15:8];
            2'b10: byte_sel = dmem.dmem_rdata[23:16];
            2'b11: byte_sel = dmem.dmem_rdata[31:24];
        endcase
    end

    assign half_sel = ALU_out_M[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

    always_comb begin
        unique case (funct3_M)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    // Abort releases the stall so the faulting instruction retires into WB.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        stall_M = 1'b0;
        pass    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_mem && !misalign) begin
                    state_d = StAccess;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = st_M & ~ld_M;
                    stall_M = 1'b1;
                end else begin
                    pass = valid_M;
                end
            end
            StAccess: begin
                if (dmem.dmem_ack) begin
                    pass    = 1'b1;
                    state_d = StIdle;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    pass    = 1'b1;
                    abort   = 1'b1;
                    state_d = StIdle;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    stall_M = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        wb_d = '0;
        if (pass) begin
            wb_d.valid     = valid_M;
            wb_d.ld        = ld_M;
            wb_d.jal       = jal_M;
            wb_d.jalr      = jalr_M;
            wb_d.lui       = lui_M;
            wb_d.reg_write = reg_write_M & ~abort & ~misalign;
            wb_d.bus_err   = abort;
`ifdef MISALIGN_TRAP_EN
            wb_d.misalign  = misalign;
`endif
            wb_d.alu_out   = ALU_out_M;
            wb_d.mem_rdata = (state_q == StAccess && !abort && ld_M) ? load_ext : 32'd0;
            wb_d.pc_plus4  = PCplus4_M;
            wb_d.imm       = immediate_M;
            wb_d.rd        = rd_M;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            wb_q    <= wb_d;
        end
    end

    assign valid_W         = wb_q.valid;
    assign ld_W            = wb_q.ld;
    assign jal_W           = wb_q.jal;
    assign jalr_W          = wb_q.jalr;
    assign lui_W           = wb_q.lui;
    assign reg_write_W     = wb_q.reg_write;
    assign bus_err_W       = wb_q.bus_err;
`ifdef MISALIGN_TRAP_EN
    assign misalign_W      = wb_q.misalign;
`endif
    assign ALU_out_W       = wb_q.alu_out;
    assign mem_read_data_W = wb_q.mem_rdata;
    assign PCplus4_W       = wb_q.pc_plus4;
    assign immediate_W     = wb_q.imm;
    assign rd_W            = wb_q.rd;

endmodule
